// File: rtl/m3ds_apb_pkg.sv
// Shared definitions for the M3 DesignStart APB initiator and its decoders.
package m3ds_apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Value of pprot that marks a secure/privileged access.
   localparam logic PPROT_SECURE = 1'b1;

   // One-hot FSM encoding of the initiator.
   typedef enum logic [3:0] {
      ST_IDLE   = 4'b0001,
      ST_SETUP  = 4'b0010,
      ST_ACCESS = 4'b0100,
      ST_RESP   = 4'b1000
   } apb_state_e;

endpackage

// File: rtl/m3ds_apb_watchdog.sv
// Saturating ACCESS-phase stall counter. Raises expire_o during the last
// allowed wait cycle. With TIMEOUT_CYCLES = 0 the counter is removed and
// expire_o is tied low.
module m3ds_apb_watchdog #(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_WIDTH      = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic unused_wd;
         assign unused_wd = ^{clk_i, rst_i, clr_i, en_i};
         assign expire_o  = 1'b0;
      end else begin : g_on
         localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
         localparam logic [CNT_WIDTH-1:0] SAT  = '1;
         logic [CNT_WIDTH-1:0] cnt;

         // Clear on reset or at SETUP; count stalled cycles, holding at all-ones.
         always_ff @(posedge clk_i) begin
            if (rst_i || clr_i) begin
               cnt <= '0;
            end else if (en_i && (cnt != SAT)) begin
               cnt <= cnt + 1'b1;
            end
         end

         assign expire_o = (cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/m3ds_apb_initiator.sv
// APB3 initiator: one command in, one APB transfer, one response out.
//
// Handshakes: a transfer on either port happens on a rising edge where
// valid and ready are both high. cmd_valid_i must stay high with stable
// fields until accepted; rsp_valid_o stays high with stable fields until
// rsp_ready_i is seen.
module m3ds_apb_initiator
   import m3ds_apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 0,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  pclk_i,
   input  logic                  preset_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [APB_ADDR_W-1:0] cmd_addr_i,
   input  logic [APB_DATA_W-1:0] cmd_wdata_i,
   input  logic                  cmd_prot_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [APB_DATA_W-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [APB_ADDR_W-1:0] paddr_o,
   output logic [APB_DATA_W-1:0] pwdata_o,
   output logic                  pprot_o,
   input  logic                  pready_i,
   input  logic                  pslverr_i,
   input  logic [APB_DATA_W-1:0] prdata_i,
   output logic [3:0]            dbg_state_o
);

   apb_state_e state;
   logic       wd_expire;

   m3ds_apb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_watchdog (
      .clk_i    (pclk_i),
      .rst_i    (preset_i),
      .clr_i    (state == ST_SETUP),
      .en_i     ((state == ST_ACCESS) && !pready_i),
      .expire_o (wd_expire)
   );

   assign dbg_state_o = state;

   // Transfer sequencer; every output is a register updated with the state.
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state         <= ST_IDLE;
         cmd_ready_o   <= 1'b0;
         psel_o        <= 1'b0;
         penable_o     <= 1'b0;
         pwrite_o      <= 1'b0;
         paddr_o       <= '0;
         pwdata_o      <= '0;
         pprot_o       <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               cmd_ready_o <= 1'b1;
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  pwrite_o    <= cmd_write_i;
                  paddr_o     <= cmd_addr_i;
                  pwdata_o    <= cmd_wdata_i;
                  pprot_o     <= cmd_prot_i;
                  psel_o      <= 1'b1;
                  state       <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_o <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // Completion takes priority over a watchdog expiring in the same cycle.
               if (pready_i) begin
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                  rsp_err_o     <= pslverr_i;
                  rsp_timeout_o <= 1'b0;
                  state         <= ST_RESP;
               end else if (wd_expire) begin
                  // Abort: psel drops without a completed transfer.
                  psel_o        <= 1'b0;
                  penable_o     <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_rdata_o   <= '0;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m3ds_apb_initiator.sv
// Self-checking bench for m3ds_apb_initiator with a 4-cycle watchdog.
module tb_m3ds_apb_initiator;
   import m3ds_apb_pkg::*;

   localparam int TMO = 4;
   localparam int RW  = 34;

   // ---------------- clock / reset ----------------
   logic pclk   = 1'b0;
   logic preset = 1'b1;
   always #5 pclk = ~pclk;

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_prot = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic [31:0] prdata = '0;
   logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o;
   logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
   logic        psel_o, penable_o, pwrite_o, pprot_o;
   logic [3:0]  dbg_state;

   m3ds_apb_initiator #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
      .pclk_i(pclk), .preset_i(preset),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_prot_i(cmd_prot),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pprot_o(pprot_o),
      .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata),
      .dbg_state_o(dbg_state)
   );

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;
   logic [RW-1:0] exp_q[$];
   int            exp_lat_q[$];

   // Observations recorded by the driver for the last transfer.
   int          obs_t0, obs_lat, obs_psel_lat, obs_pen_lat, obs_pen_cnt;
   logic [31:0] obs_rdata;
   logic        obs_err, obs_to, obs_stable, obs_hold_ok, obs_after_ok;

   function automatic logic [103:0] outs_vec();
      return {cmd_ready_o, psel_o, penable_o, pwrite_o, pprot_o, paddr_o, pwdata_o,
              rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o};
   endfunction

   // ---------------- driver ----------------
   // Issues one command and plays an APB slave that inserts `waits` wait
   // states, then holds off the response for `hold` cycles.
   task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic prot, input int waits, input logic [31:0] rd,
                          input logic serr, input int hold);
      int  n;
      bit  done;
      obs_lat = -1; obs_psel_lat = -1; obs_pen_lat = -1; obs_pen_cnt = 0;
      obs_rdata = '0; obs_err = 1'b0; obs_to = 1'b0;
      obs_stable = 1'b1; obs_hold_ok = 1'b1; obs_after_ok = 1'b0;
      n = 0;
      while (!cmd_ready_o && n < 20) begin
         @(negedge pclk);
         n++;
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_prot = prot;
      obs_t0 = cyc;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge pclk);
         cmd_valid = 1'b0;
         cmd_write = 1'($urandom); cmd_prot = 1'($urandom);
         cmd_addr = $urandom; cmd_wdata = $urandom;
         if (psel_o) begin
            if (obs_psel_lat < 0) obs_psel_lat = cyc - obs_t0;
            if (paddr_o !== addr || pwdata_o !== wd || pwrite_o !== wr || pprot_o !== prot)
               obs_stable = 1'b0;
         end
         if (psel_o && penable_o) begin
            if (obs_pen_lat < 0) obs_pen_lat = cyc - obs_t0;
            obs_pen_cnt++;
            pready  = (obs_pen_cnt > waits);
            pslverr = pready ? serr : 1'b1;
            prdata  = pready ? rd : $urandom;
         end else begin
            pready  = 1'b0;
            pslverr = 1'($urandom);
            prdata  = $urandom;
         end
         if (rsp_valid_o) begin
            done = 1'b1;
            obs_lat = cyc - obs_t0;
            obs_rdata = rsp_rdata_o; obs_err = rsp_err_o; obs_to = rsp_timeout_o;
            for (int h = 0; h <= hold; h++) begin
               if (h > 0) begin
                  @(negedge pclk);
                  pslverr = 1'($urandom);
                  prdata  = $urandom;
               end
               if (rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || psel_o !== 1'b0 ||
                   rsp_rdata_o !== obs_rdata || rsp_err_o !== obs_err || rsp_timeout_o !== obs_to)
                  obs_hold_ok = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge pclk);
            rsp_ready = 1'b0;
            obs_after_ok = (rsp_valid_o === 1'b0 && cmd_ready_o === 1'b1);
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      preset = 1'b1;
      repeat (3) @(negedge pclk);
      checks++;
      if (outs_vec() !== '0) begin
         errors++; $display("FAIL reset_outputs: got %0h required 0", outs_vec());
      end
      checks++;
      if (dbg_state !== 4'(ST_IDLE)) begin
         errors++; $display("FAIL reset_state: got %0h required %0h", dbg_state, 4'(ST_IDLE));
      end
      preset = 1'b0;
      @(negedge pclk);
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready: got %0b required 1", cmd_ready_o);
      end
   endtask

   task automatic test_zero_wait_write();
      do_xfer(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, PPROT_SECURE, 0, $urandom, 1'b0, 0);
      checks++;
      if (obs_psel_lat !== 1) begin errors++; $display("FAIL zw_psel_lat: got %0d required 1", obs_psel_lat); end
      checks++;
      if (obs_pen_lat !== 2) begin errors++; $display("FAIL zw_pen_lat: got %0d required 2", obs_pen_lat); end
      checks++;
      if (obs_lat !== 3) begin errors++; $display("FAIL zw_rsp_lat: got %0d required 3", obs_lat); end
      checks++;
      if ({obs_err, obs_to, obs_rdata} !== 34'h0) begin
         errors++; $display("FAIL zw_rsp: got err=%0b to=%0b rdata=%0h required 0/0/0", obs_err, obs_to, obs_rdata);
      end
      checks++;
      if (!(obs_stable && obs_after_ok)) begin
         errors++; $display("FAIL zw_stable: got stable=%0b after=%0b required 1/1", obs_stable, obs_after_ok);
      end
   endtask

   task automatic test_read_wait3();
      do_xfer(1'b0, 32'h0000_2008, $urandom, 1'b0, 3, 32'h1234_5678, 1'b0, 0);
      checks++;
      if (obs_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd3_rdata: got %0h required 12345678", obs_rdata); end
      checks++;
      if (obs_lat !== 6) begin errors++; $display("FAIL rd3_lat: got %0d required 6", obs_lat); end
      checks++;
      if (obs_pen_cnt !== 4) begin errors++; $display("FAIL rd3_penable_cycles: got %0d required 4", obs_pen_cnt); end
      checks++;
      if (obs_err !== 1'b0 || !obs_stable) begin
         errors++; $display("FAIL rd3_err_stable: got err=%0b stable=%0b required 0/1", obs_err, obs_stable);
      end
   endtask

   task automatic test_slave_error();
      do_xfer(1'b0, 32'h0000_0040, $urandom, 1'b0, 2, 32'hCAFE_0001, 1'b1, 0);
      checks++;
      if (obs_err !== 1'b1 || obs_to !== 1'b0) begin
         errors++; $display("FAIL slverr: got err=%0b to=%0b required 1/0", obs_err, obs_to);
      end
      // pslverr is driven high in the wait cycles only; it must be ignored.
      do_xfer(1'b1, 32'h0000_0044, 32'h5555_AAAA, 1'b0, 2, $urandom, 1'b0, 0);
      checks++;
      if (obs_err !== 1'b0 || obs_to !== 1'b0) begin
         errors++; $display("FAIL slverr_ignored: got err=%0b to=%0b required 0/0", obs_err, obs_to);
      end
   endtask

   task automatic test_timeout();
      do_xfer(1'b0, 32'h0000_0300, $urandom, 1'b0, 1000, 32'hFFFF_0000, 1'b0, 0);
      checks++;
      if (obs_lat !== 2 + TMO) begin errors++; $display("FAIL tmo_lat: got %0d required %0d", obs_lat, 2 + TMO); end
      checks++;
      if ({obs_err, obs_to, obs_rdata} !== {1'b1, 1'b1, 32'h0}) begin
         errors++; $display("FAIL tmo_rsp: got err=%0b to=%0b rdata=%0h required 1/1/0", obs_err, obs_to, obs_rdata);
      end
      checks++;
      if (obs_pen_cnt !== TMO) begin errors++; $display("FAIL tmo_access_cycles: got %0d required %0d", obs_pen_cnt, TMO); end
      // pready arrives in the last allowed cycle: normal completion.
      do_xfer(1'b0, 32'h0000_0304, $urandom, 1'b0, TMO - 1, 32'h0BAD_F00D, 1'b0, 0);
      checks++;
      if ({obs_err, obs_to, obs_rdata} !== {1'b0, 1'b0, 32'h0BAD_F00D} || obs_lat !== 2 + TMO) begin
         errors++; $display("FAIL tmo_edge: got err=%0b to=%0b rdata=%0h lat=%0d required 0/0/0badf00d/%0d",
                            obs_err, obs_to, obs_rdata, obs_lat, 2 + TMO);
      end
   endtask

   task automatic test_backpressure();
      int c_after;
      do_xfer(1'b0, 32'h0000_0500, $urandom, 1'b1, 1, 32'h7777_1111, 1'b0, 5);
      checks++;
      if (!obs_hold_ok || obs_rdata !== 32'h7777_1111) begin
         errors++; $display("FAIL bp_hold: got hold_ok=%0b rdata=%0h required 1/77771111", obs_hold_ok, obs_rdata);
      end
      checks++;
      if (!obs_after_ok) begin errors++; $display("FAIL bp_after: got 0 required 1"); end
      c_after = cyc;
      do_xfer(1'b1, 32'h0000_0504, 32'h1, 1'b0, 0, $urandom, 1'b0, 0);
      checks++;
      if (obs_t0 !== c_after || obs_lat !== 3) begin
         errors++; $display("FAIL bp_next_accept: got t0=%0d lat=%0d required %0d/3", obs_t0, obs_lat, c_after);
      end
   endtask

   task automatic test_back_to_back();
      int t_prev;
      do_xfer(1'b1, 32'h0000_0600, 32'hA, 1'b0, 0, $urandom, 1'b0, 0);
      t_prev = obs_t0;
      for (int i = 0; i < 3; i++) begin
         do_xfer(1'(i), 32'h0000_0604 + 32'(4 * i), $urandom, 1'b0, 0, $urandom, 1'b0, 0);
         checks++;
         if (obs_t0 - t_prev !== 4) begin
            errors++; $display("FAIL b2b_spacing_%0d: got %0d required 4", i, obs_t0 - t_prev);
         end
         t_prev = obs_t0;
      end
   endtask

   task automatic test_reset_mid_access();
      int n;
      bit seen;
      n = 0;
      while (!cmd_ready_o && n < 20) begin @(negedge pclk); n++; end
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0700; cmd_prot = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      n = 0;
      while (!(psel_o && penable_o) && n < 10) begin @(negedge pclk); n++; end
      pready = 1'b0; pslverr = 1'b0;
      @(negedge pclk);
      checks++;
      if (!(psel_o && penable_o)) begin errors++; $display("FAIL rstmid_in_access: got psel=%0b penable=%0b required 1/1", psel_o, penable_o); end
      preset = 1'b1;
      @(negedge pclk);
      checks++;
      if (outs_vec() !== '0) begin errors++; $display("FAIL rstmid_outputs: got %0h required 0", outs_vec()); end
      preset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         if (rsp_valid_o) seen = 1'b1;
      end
      checks++;
      if (seen || cmd_ready_o !== 1'b1) begin
         errors++; $display("FAIL rstmid_no_rsp: got rsp_seen=%0b cmd_ready=%0b required 0/1", seen, cmd_ready_o);
      end
      do_xfer(1'b0, 32'h0000_0708, $urandom, 1'b0, 1, 32'h2468_ACE0, 1'b0, 0);
      checks++;
      if (obs_rdata !== 32'h2468_ACE0 || obs_lat !== 4 || obs_err !== 1'b0) begin
         errors++; $display("FAIL rstmid_recover: got rdata=%0h lat=%0d err=%0b required 2468ace0/4/0", obs_rdata, obs_lat, obs_err);
      end
   endtask

   task automatic test_random();
      logic          wr, prot, serr;
      logic [31:0]   addr, wd, rd;
      int            waits, hold, el;
      logic [RW-1:0] exp;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom); prot = 1'($urandom); serr = 1'($urandom);
         addr = $urandom; wd = $urandom; rd = $urandom;
         waits = $urandom_range(6, 0); hold = $urandom_range(2, 0);
         // Reference: a slave ready within TMO access cycles completes normally.
         if (waits < TMO) begin
            exp_q.push_back({serr, 1'b0, wr ? 32'h0 : rd});
            exp_lat_q.push_back(3 + waits);
         end else begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            exp_lat_q.push_back(2 + TMO);
         end
         do_xfer(wr, addr, wd, prot, waits, rd, serr, hold);
         exp = exp_q.pop_front();
         el  = exp_lat_q.pop_front();
         checks++;
         if ({obs_err, obs_to, obs_rdata} !== exp) begin
            errors++; $display("FAIL rnd_rsp_%0d: got %0h required %0h", i, {obs_err, obs_to, obs_rdata}, exp);
         end
         checks++;
         if (obs_lat !== el) begin errors++; $display("FAIL rnd_lat_%0d: got %0d required %0d", i, obs_lat, el); end
         checks++;
         if (!(obs_stable && obs_hold_ok && obs_after_ok)) begin
            errors++; $display("FAIL rnd_protocol_%0d: got stable=%0b hold=%0b after=%0b required 1/1/1",
                               i, obs_stable, obs_hold_ok, obs_after_ok);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_zero_wait_write();
      test_read_wait3();
      test_slave_error();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_time_limit: simulation did not complete");
      $fatal(1);
   end

endmodule
